// File: rtl/dec_ib_src_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dec_ib_src_arb : N-source instruction-buffer arbiter + decode register   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dec_ib_src_arb #(
   parameter int NSRC      = 2,
   parameter int NLANE     = 2,
   parameter int PKT_W     = 85,
   parameter int SB_W      = 2,
   parameter int PRIO_MODE = 0
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic                           flush,
   input  logic [NSRC*NLANE-1:0]          src_vld,
   input  logic [NSRC*NLANE*PKT_W-1:0]    src_pkt,
   input  logic [NSRC*SB_W-1:0]           src_sb,
   output logic [NSRC-1:0]                src_ack,
   input  logic [$clog2(NLANE+1)-1:0]     take_cnt,
   output logic [NLANE-1:0]               out_vld,
   output logic [NLANE*PKT_W-1:0]         out_pkt,
   output logic [SB_W-1:0]                out_sb,
   output logic [$clog2(NSRC)-1:0]        out_src,
   output logic [NLANE*31-1:0]            out_pc,
   output logic [NLANE-1:0]               out_pc4,
   output logic [NLANE*4-1:0]             out_err,
   output logic                           out_icaf2
);

   localparam int c_src_w  = $clog2(NSRC);
   localparam int c_take_w = $clog2(NLANE+1);
   localparam int c_grp_w  = NLANE*PKT_W;

   logic [NLANE-1:0]    r_vld;
   logic [c_grp_w-1:0]  r_pkt;
   logic [SB_W-1:0]     r_sb;
   logic [c_src_w-1:0]  r_src;
   logic [c_src_w-1:0]  r_rr;

   logic [c_take_w-1:0] w_cnt;
   logic [c_take_w-1:0] w_take;
   logic [NSRC-1:0]     w_req;
   logic                w_can_load;
   logic                w_load;
   logic [c_src_w-1:0]  w_win;
   logic [c_src_w-1:0]  w_idx;
   logic [c_src_w-1:0]  w_rr_nxt;
   logic [NLANE-1:0]    w_win_vld;
   logic [c_grp_w-1:0]  w_win_pkt;
   logic [SB_W-1:0]     w_win_sb;
   logic [NLANE-1:0]    w_sh_vld;
   logic [c_grp_w-1:0]  w_sh_pkt;

   always_comb begin
      w_cnt = '0;
      for (int l = 0; l < NLANE; l++)
         w_cnt = w_cnt + c_take_w'(r_vld[l]);
   end

   // Surplus take beyond what is held is simply ignored.
   assign w_take     = (take_cnt > w_cnt) ? w_cnt : take_cnt;
   assign w_can_load = (w_take == w_cnt) & ~flush;
   assign w_load     = rst_l & w_can_load & (|w_req);

   generate
      for (genvar s = 0; s < NSRC; s++) begin : g_req
         assign w_req[s]   = |src_vld[s*NLANE +: NLANE];
         assign src_ack[s] = w_load & (w_win == c_src_w'(s));
      end
   endgenerate

   always_comb begin
      w_win = '0;
      w_idx = '0;
      if (PRIO_MODE == 0) begin
         for (int s = 0; s < NSRC; s++)
            if (w_req[s]) w_win = c_src_w'(s);
      end else begin
         // Walk from farthest to nearest so the first request at/after rr wins.
         for (int k = NSRC-1; k >= 0; k--) begin
            w_idx = c_src_w'((int'(r_rr) + k) % NSRC);
            if (w_req[w_idx]) w_win = w_idx;
         end
      end
   end

   assign w_rr_nxt = (int'(w_win) == NSRC-1) ? '0 : w_win + 1'b1;

   always_comb begin
      w_win_vld = src_vld[w_win*NLANE +: NLANE];
      w_win_pkt = src_pkt[w_win*c_grp_w +: c_grp_w];
      w_win_sb  = src_sb[w_win*SB_W +: SB_W];
      for (int l = 0; l < NLANE; l++)
         if (!w_win_vld[l]) w_win_pkt[l*PKT_W +: PKT_W] = '0;
   end

   // Shift by the effective take; a take of zero holds, a full take empties.
   always_comb begin
      w_sh_vld = '0;
      w_sh_pkt = '0;
      for (int l = 0; l < NLANE; l++) begin
         for (int t = 0; t <= NLANE; t++) begin
            if ((int'(w_take) == t) && (l + t < NLANE)) begin
               w_sh_vld[l]                 = r_vld[l+t];
               w_sh_pkt[l*PKT_W +: PKT_W]  = r_pkt[(l+t)*PKT_W +: PKT_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_vld <= '0;
         r_pkt <= '0;
         r_sb  <= '0;
         r_src <= '0;
         r_rr  <= '0;
      end else if (flush) begin
         r_vld <= '0;
         r_pkt <= '0;
      end else if (w_load) begin
         r_vld <= w_win_vld;
         r_pkt <= w_win_pkt;
         r_sb  <= w_win_sb;
         r_src <= w_win;
         r_rr  <= w_rr_nxt;
      end else begin
         r_vld <= w_sh_vld;
         r_pkt <= w_sh_pkt;
      end
   end

   assign out_vld   = r_vld;
   assign out_pkt   = r_pkt;
   assign out_sb    = r_sb;
   assign out_src   = r_src;
   assign out_icaf2 = r_pkt[36];

   generate
      for (genvar l = 0; l < NLANE; l++) begin : g_dec
         assign out_pc[l*31 +: 31] = r_pkt[l*PKT_W+1  +: 31];
         assign out_pc4[l]         = r_pkt[l*PKT_W];
         assign out_err[l*4 +: 4]  = r_pkt[l*PKT_W+32 +: 4];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dec_ib_src_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dec_ib_src_arb : directed bench, fixed-prio (2 src) and RR (3 src)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dec_ib_src_arb;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   // instance a: NSRC=2, fixed priority
   logic         a_rst_l, a_flush;
   logic [3:0]   a_src_vld;
   logic [339:0] a_src_pkt;
   logic [3:0]   a_src_sb;
   logic [1:0]   a_src_ack;
   logic [1:0]   a_take;
   logic [1:0]   a_out_vld;
   logic [169:0] a_out_pkt;
   logic [1:0]   a_out_sb;
   logic [0:0]   a_out_src;
   logic [61:0]  a_out_pc;
   logic [1:0]   a_out_pc4;
   logic [7:0]   a_out_err;
   logic         a_out_icaf2;

   // instance b: NSRC=3, round-robin
   logic         b_rst_l, b_flush;
   logic [5:0]   b_src_vld;
   logic [509:0] b_src_pkt;
   logic [5:0]   b_src_sb;
   logic [2:0]   b_src_ack;
   logic [1:0]   b_take;
   logic [1:0]   b_out_vld;
   logic [169:0] b_out_pkt;
   logic [1:0]   b_out_sb;
   logic [1:0]   b_out_src;
   logic [61:0]  b_out_pc;
   logic [1:0]   b_out_pc4;
   logic [7:0]   b_out_err;
   logic         b_out_icaf2;

   dec_ib_src_arb #(.NSRC(2), .NLANE(2), .PKT_W(85), .SB_W(2), .PRIO_MODE(0)) u_dut_a (
      .clk(clk), .rst_l(a_rst_l), .flush(a_flush), .src_vld(a_src_vld), .src_pkt(a_src_pkt),
      .src_sb(a_src_sb), .src_ack(a_src_ack), .take_cnt(a_take), .out_vld(a_out_vld),
      .out_pkt(a_out_pkt), .out_sb(a_out_sb), .out_src(a_out_src), .out_pc(a_out_pc),
      .out_pc4(a_out_pc4), .out_err(a_out_err), .out_icaf2(a_out_icaf2));

   dec_ib_src_arb #(.NSRC(3), .NLANE(2), .PKT_W(85), .SB_W(2), .PRIO_MODE(1)) u_dut_b (
      .clk(clk), .rst_l(b_rst_l), .flush(b_flush), .src_vld(b_src_vld), .src_pkt(b_src_pkt),
      .src_sb(b_src_sb), .src_ack(b_src_ack), .take_cnt(b_take), .out_vld(b_out_vld),
      .out_pkt(b_out_pkt), .out_sb(b_out_sb), .out_src(b_out_src), .out_pc(b_out_pc),
      .out_pc4(b_out_pc4), .out_err(b_out_err), .out_icaf2(b_out_icaf2));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [84:0] mk_lane(input logic [31:0] pc, input logic [4:0] fld);
      return {48'hABCD_1234_5678, fld, pc};
   endfunction

   initial begin
      // src0: pc 0x200/0x204 sb=01 ; src1: pc 0x101(pc4)/0x104, lane0 fields 10101, sb=10
      a_src_pkt = {mk_lane(32'h104, 5'b0), mk_lane(32'h101, 5'b10101),
                   mk_lane(32'h204, 5'b0), mk_lane(32'h200, 5'b0)};
      a_src_sb  = 4'b10_01;
      a_rst_l = 1'b0; a_flush = 1'b0; a_src_vld = 4'b1111; a_take = 2'd0;
      b_rst_l = 1'b0; b_flush = 1'b0; b_src_vld = 6'b0;   b_take = 2'd0;
      b_src_pkt = '0; b_src_sb = '0;

      // reset with all sources requesting
      tick(); tick();
      chk("rst_out_vld", 64'(a_out_vld), 64'h0);
      chk("rst_ack",     64'(a_src_ack), 64'h0);
      chk("rst_out_src", 64'(a_out_src), 64'h0);

      // release: fixed priority picks src1
      a_rst_l = 1'b1; #1;
      chk("fp_ack", 64'(a_src_ack), 64'h2);
      tick();
      chk("fp_out_src", 64'(a_out_src), 64'h1);
      chk("fp_out_vld", 64'(a_out_vld), 64'h3);
      chk("fp_out_sb",  64'(a_out_sb),  64'h2);
      chk("fld_icaf2",  64'(a_out_icaf2), 64'h1);
      chk("fld_err0",   64'(a_out_err[3:0]), 64'h5);
      chk("fld_pc4",    64'(a_out_pc4), 64'h1);
      chk("fld_pc0",    64'(a_out_pc[30:0]), 64'h80);

      // partial take of one lane: no ack, shift down
      a_src_vld = 4'b0011; a_take = 2'd1; #1;
      chk("part_ack", 64'(a_src_ack), 64'h0);
      tick();
      chk("part_vld",  64'(a_out_vld), 64'h1);
      chk("part_pc0",  64'(a_out_pc[30:0]), 64'h82);
      chk("part_pc1",  64'(a_out_pc[61:31]), 64'h0);
      chk("part_src",  64'(a_out_src), 64'h1);
      chk("part_sb",   64'(a_out_sb), 64'h2);

      // drain last lane and refill from src0 in the same cycle
      #1;
      chk("refill_ack", 64'(a_src_ack), 64'h1);
      tick();
      chk("refill_src", 64'(a_out_src), 64'h0);
      chk("refill_vld", 64'(a_out_vld), 64'h3);
      chk("refill_pc0", 64'(a_out_pc[30:0]), 64'h100);
      chk("refill_sb",  64'(a_out_sb), 64'h1);

      // flush beats load
      a_flush = 1'b1; a_src_vld = 4'b1100; a_take = 2'd2; #1;
      chk("flush_ack", 64'(a_src_ack), 64'h0);
      tick();
      chk("flush_vld", 64'(a_out_vld), 64'h0);
      a_flush = 1'b0; a_take = 2'd0; #1;
      chk("postflush_ack", 64'(a_src_ack), 64'h2);
      tick();
      chk("postflush_src", 64'(a_out_src), 64'h1);
      chk("postflush_vld", 64'(a_out_vld), 64'h3);

      // take 3 with 2 held is a full take
      a_take = 2'd3; a_src_vld = 4'b0011; #1;
      chk("take3_ack", 64'(a_src_ack), 64'h1);
      tick();
      chk("take3_src", 64'(a_out_src), 64'h0);
      a_src_vld = 4'b0000; #1;
      chk("drain_ack", 64'(a_src_ack), 64'h0);
      tick();
      chk("drain_vld", 64'(a_out_vld), 64'h0);
      chk("drain_pc",  64'(a_out_pc), 64'h0);
      chk("drain_err", 64'(a_out_err), 64'h0);

      // reset while holding drops everything
      a_take = 2'd0; a_src_vld = 4'b1100;
      tick();
      chk("hold_vld", 64'(a_out_vld), 64'h3);
      a_rst_l = 1'b0; #1;
      chk("midrst_ack", 64'(a_src_ack), 64'h0);
      tick();
      chk("midrst_vld", 64'(a_out_vld), 64'h0);
      chk("midrst_src", 64'(a_out_src), 64'h0);
      a_rst_l = 1'b1; a_src_vld = 4'b0000;

      // round-robin: ptr 0 -> 1 -> 2 -> wrap to 0
      b_src_vld = 6'b111111; b_take = 2'd2;
      tick();
      b_rst_l = 1'b1; #1;
      chk("rr_ack0", 64'(b_src_ack), 64'h1);
      tick();
      chk("rr_src0", 64'(b_out_src), 64'h0);
      chk("rr_ack1", 64'(b_src_ack), 64'h2);
      tick();
      chk("rr_src1", 64'(b_out_src), 64'h1);
      chk("rr_ack2", 64'(b_src_ack), 64'h4);
      tick();
      chk("rr_src2", 64'(b_out_src), 64'h2);
      chk("rr_wrap_ack", 64'(b_src_ack), 64'h1);
      tick();
      chk("rr_wrap_src", 64'(b_out_src), 64'h0);
      chk("rr_vld", 64'(b_out_vld), 64'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
